// File: rtl/rotor_stepper.sv
// Enigma rotor-position stepper: notch turnover, settle window and encode-valid strobe.
// Optional `ROTOR_DOUBLE_STEP_EN enables the middle-rotor double step (odometer stepping otherwise).
module rotor_stepper #(
  parameter int NOTCH_FAST    = 16,
  parameter int NOTCH_MID     = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_stb,
  input  logic       load,
  input  logic [4:0] init_slow,
  input  logic [4:0] init_mid,
  input  logic [4:0] init_fast,
  output logic [4:0] rot_slow,
  output logic [4:0] rot_mid,
  output logic [4:0] rot_fast,
  output logic       busy,
  output logic       enc_valid
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [4:0] NF       = 5'(NOTCH_FAST);
  localparam logic [4:0] NM       = 5'(NOTCH_MID);
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [4:0] slow_nx, mid_nx, fast_nx;
  logic       fast_hit, mid_hit, step_mid, step_slow;

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] red26(input logic [4:0] v);
    return (v >= 5'd26) ? v - 5'd26 : v;
  endfunction

  // All carries are decided from the pre-step positions.
  always_comb begin
    fast_hit = (rot_fast == NF);
    mid_hit  = (rot_mid == NM);
`ifdef ROTOR_DOUBLE_STEP_EN
    step_mid  = fast_hit | mid_hit;
    step_slow = mid_hit;
`else
    step_mid  = fast_hit;
    step_slow = fast_hit & mid_hit;
`endif
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    slow_nx  = rot_slow;
    mid_nx   = rot_mid;
    fast_nx  = rot_fast;
    if (load) begin
      slow_nx  = red26(init_slow);
      mid_nx   = red26(init_mid);
      fast_nx  = red26(init_fast);
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_stb) begin
            fast_nx  = inc26(rot_fast);
            mid_nx   = step_mid  ? inc26(rot_mid)  : rot_mid;
            slow_nx  = step_slow ? inc26(rot_slow) : rot_slow;
            cnt_nx   = CNT_INIT;
            state_nx = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) state_nx = DONE;
          else           cnt_nx   = cnt - 4'd1;
        end
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // busy/enc_valid are flops decoded from the next state so they track the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rot_slow  <= '0;
      rot_mid   <= '0;
      rot_fast  <= '0;
      busy      <= 1'b0;
      enc_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rot_slow  <= slow_nx;
      rot_mid   <= mid_nx;
      rot_fast  <= fast_nx;
      busy      <= (state_nx != IDLE);
      enc_valid <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_rotor_stepper.sv
// Self-checking bench for rotor_stepper: vector table, corner sequences, randomized model check.
module tb_rotor_stepper;
  localparam int S  = 4;
  localparam int NF = 16;
  localparam int NM = 4;

  logic       clk = 1'b0;
  logic       rst_n, key_stb, load;
  logic [4:0] init_slow, init_mid, init_fast;
  logic [4:0] rot_slow, rot_mid, rot_fast;
  logic       busy, enc_valid;

  int n_cmp = 0;
  int n_err = 0;
  int ms, mm, mf;

  rotor_stepper #(.NOTCH_FAST(NF), .NOTCH_MID(NM), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .key_stb(key_stb), .load(load),
    .init_slow(init_slow), .init_mid(init_mid), .init_fast(init_fast),
    .rot_slow(rot_slow), .rot_mid(rot_mid), .rot_fast(rot_fast),
    .busy(busy), .enc_valid(enc_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int i_s, i_m, i_f;
    int e_s, e_m, e_f;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rot(input string name, input int s, input int m, input int f);
    chk({name, ".slow"}, int'(rot_slow), s);
    chk({name, ".mid"},  int'(rot_mid),  m);
    chk({name, ".fast"}, int'(rot_fast), f);
  endtask

  // Reference: Enigma stepping on positions modulo 26.
  function automatic void model_step();
    bit carry_m, carry_s;
`ifdef ROTOR_DOUBLE_STEP_EN
    carry_m = (mf == NF) || (mm == NM);
    carry_s = (mm == NM);
`else
    carry_m = (mf == NF);
    carry_s = (mf == NF) && (mm == NM);
`endif
    mf = (mf + 1) % 26;
    mm = (mm + (carry_m ? 1 : 0)) % 26;
    ms = (ms + (carry_s ? 1 : 0)) % 26;
  endfunction

  task automatic do_load(input int s, input int m, input int f);
    load = 1'b1;
    init_slow = 5'(s); init_mid = 5'(m); init_fast = 5'(f);
    tick();
    load = 1'b0;
    ms = s % 26; mm = m % 26; mf = f % 26;
    chk_rot("load", ms, mm, mf);
    chk("load.busy", int'(busy), 0);
    chk("load.enc_valid", int'(enc_valid), 0);
  endtask

  // Full keystroke with cycle-exact busy/enc_valid checks.
  task automatic press_key(input string name);
    key_stb = 1'b1;
    tick();
    key_stb = 1'b0;
    model_step();
    chk_rot(name, ms, mm, mf);
    chk({name, ".busy0"}, int'(busy), 1);
    chk({name, ".enc0"}, int'(enc_valid), 0);
    for (int i = 1; i <= S; i++) begin
      tick();
      chk({name, ".busy"}, int'(busy), 1);
      chk({name, ".enc"}, int'(enc_valid), (i == S) ? 1 : 0);
    end
    chk_rot({name, ".hold"}, ms, mm, mf);
    tick();
    chk({name, ".busy_end"}, int'(busy), 0);
    chk({name, ".enc_end"}, int'(enc_valid), 0);
  endtask

  initial begin
    vec_t vecs[8];
    int enc_cnt, busy_cnt;

    vecs[0] = '{0, 0, 0, 0, 0, 1};
    vecs[1] = '{0, 0, 16, 0, 1, 17};
    vecs[2] = '{0, 0, 25, 0, 0, 0};
    vecs[3] = '{0, 3, 16, 0, 4, 17};
`ifdef ROTOR_DOUBLE_STEP_EN
    vecs[4] = '{0, 4, 10, 1, 5, 11};
`else
    vecs[4] = '{0, 4, 10, 0, 4, 11};
`endif
    vecs[5] = '{25, 4, 16, 0, 5, 17};
    vecs[6] = '{5, 25, 16, 5, 0, 17};
    vecs[7] = '{31, 26, 27, 5, 0, 2};

    rst_n = 1'b0; key_stb = 1'b0; load = 1'b0;
    init_slow = '0; init_mid = '0; init_fast = '0;
    ms = 0; mm = 0; mf = 0;
    tick(); tick();
    chk_rot("reset", 0, 0, 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.enc", int'(enc_valid), 0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 8; v++) begin
      do_load(vecs[v].i_s, vecs[v].i_m, vecs[v].i_f);
      press_key($sformatf("vec%0d", v));
      chk_rot($sformatf("vec%0d.exp", v), vecs[v].e_s, vecs[v].e_m, vecs[v].e_f);
    end

    // Double step over two consecutive keys.
    do_load(0, 3, 16);
    press_key("dbl1");
    chk_rot("dbl1.exp", 0, 4, 17);
    press_key("dbl2");
`ifdef ROTOR_DOUBLE_STEP_EN
    chk_rot("dbl2.exp", 1, 5, 18);
`else
    chk_rot("dbl2.exp", 0, 4, 18);
`endif

    do_load(31, 26, 27);
    chk_rot("reduce", 5, 0, 1);

    // Key strobe during SETTLE is dropped.
    do_load(2, 7, 9);
    key_stb = 1'b1; tick(); key_stb = 1'b0;
    model_step();
    enc_cnt = 0;
    tick();
    key_stb = 1'b1; tick(); key_stb = 1'b0;
    if (enc_valid) enc_cnt++;
    for (int i = 0; i < S + 4; i++) begin
      tick();
      if (enc_valid) enc_cnt++;
    end
    chk("drop.enc_count", enc_cnt, 1);
    chk_rot("drop.rot", ms, mm, mf);
    chk("drop.busy", int'(busy), 0);

    // Load aborts an in-flight keystroke.
    key_stb = 1'b1; tick(); key_stb = 1'b0;
    tick();
    do_load(1, 2, 3);
    chk_rot("abort.rot", 1, 2, 3);
    enc_cnt = 0;
    for (int i = 0; i < S + 3; i++) begin
      tick();
      if (enc_valid) enc_cnt++;
    end
    chk("abort.enc_count", enc_cnt, 0);

    // Asynchronous reset mid-SETTLE.
    do_load(3, 4, 5);
    key_stb = 1'b1; tick(); key_stb = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_rot("areset", 0, 0, 0);
    chk("areset.busy", int'(busy), 0);
    chk("areset.enc", int'(enc_valid), 0);
    tick(); tick();
    rst_n = 1'b1;
    ms = 0; mm = 0; mf = 0;
    enc_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < S + 3; i++) begin
      tick();
      if (enc_valid) enc_cnt++;
      if (busy) busy_cnt++;
    end
    chk("areset.enc_count", enc_cnt, 0);
    chk("areset.busy_count", busy_cnt, 0);
    chk_rot("areset.post", 0, 0, 0);

    // Randomized loads and keys against the reference model.
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        int f;
        case ($urandom_range(0, 2))
          0:       f = NF - 1;
          1:       f = NF;
          default: f = $urandom_range(0, 31);
        endcase
        do_load($urandom_range(0, 31),
                ($urandom_range(0, 1) == 1) ? NM : $urandom_range(0, 31), f);
      end else begin
        press_key($sformatf("rnd%0d", it));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rotor_stepper.md
# rotor_stepper

Registered rotor-position controller for the Enigma datapath. On each debounced key strobe it advances the three rotor offsets by Enigma stepping rules, with notch turnover and the middle-rotor double step. It then holds the new offsets stable for a configurable settle window and flags when the combinational rotor/reflector/inverse-rotor chain output may be sampled. It drives the `rotate` inputs of every rotor stage and its inverse: `rot_fast` feeds rotor3/rotor3_inv, `rot_mid` feeds rotor2/rotor2_inv, `rot_slow` feeds rotor1/rotor1_inv.

## Interface
- `NOTCH_FAST`, default 16: fast-rotor position at which the middle rotor is carried (Q→R turnover).
- `NOTCH_MID`, default 4: middle-rotor position at which the slow rotor is carried (E→F turnover).
- `SETTLE_CYCLES`, default 4: cycles offsets are held before `enc_valid`; legal range 1..15.

Ports:
- `clk`  in  1: system clock; all state is updated on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `key_stb`  in  1: single-cycle key-press strobe, already debounced upstream.
- `load`  in  1: load initial positions (ring setting).
- `init_slow`, `init_mid`, `init_fast`  in  5 each: positions applied on `load`.
- `rot_slow`, `rot_mid`, `rot_fast`  out  5 each: registered rotor offsets, always in 0..25.
- `busy`  out  1: high while a keystroke is in flight (SETTLE or DONE).
- `enc_valid`  out  1: one-cycle pulse; chain output is valid to latch.

## Operation
- Reset values: all `rot_*` = 0, `busy` = 0, `enc_valid` = 0, state = IDLE, settle counter = 0.
- FSM states:
  - IDLE: `key_stb`=1 → step the rotors, load counter = `SETTLE_CYCLES`-1, go to SETTLE.
  - SETTLE: counter==0 → go to DONE; otherwise decrement the counter.
  - DONE: go to IDLE unconditionally.
- Outputs are registered: `busy` = (state != IDLE), `enc_valid` = (state == DONE).
- Stepping happens before encryption, as on the real machine. Evaluate all rotors from the pre-step values, then update them simultaneously:
  - Fast rotor always steps.
  - Middle rotor steps if fast == `NOTCH_FAST`, or (double step) if mid == `NOTCH_MID`.
  - Slow rotor steps if mid == `NOTCH_MID`.
- Increment arithmetic: 5-bit, 25 + 1 → 0. No value of 26..31 is ever driven.
- `load` is honoured in any state and takes priority over `key_stb`:
  - Writes `init_*` into `rot_*`, reducing values 26..31 by 26.
  - Forces IDLE and clears the counter.
  - Aborts an in-flight keystroke; no `enc_valid` is emitted for it.
- `key_stb` outside IDLE is ignored (dropped, not queued).
- Reset asserted mid-keystroke: immediate return to reset values; `enc_valid` is never emitted.

## Timing
- `key_stb` sampled high in IDLE at edge k:
  - New `rot_*` and `busy`=1 are visible after edge k.
  - State is DONE after edge k+`SETTLE_CYCLES`; `enc_valid` is high for exactly the one cycle following it.
  - `busy` drops after edge k+`SETTLE_CYCLES`+1.
- Minimum key-to-key spacing: `SETTLE_CYCLES`+2 cycles.
- `load` at edge k: `rot_*` are updated after edge k; `busy`=0 and `enc_valid`=0 after edge k.
- `rot_*` change only at a stepping edge or a `load` edge. They are stable throughout SETTLE and DONE.

## Configuration
- `ROTOR_DOUBLE_STEP_EN` defined: middle-rotor double-step clause is active, as described in Operation.
- `ROTOR_DOUBLE_STEP_EN` undefined: pure odometer stepping:
  - Middle rotor steps only when fast == `NOTCH_FAST`.
  - Slow rotor steps only when mid == `NOTCH_MID` and fast == `NOTCH_FAST`.

## Test plan
- Reset: hold `rst_n`=0 mid-SETTLE → all `rot_*`=0, `busy`=0, `enc_valid`=0 asynchronously; no pulse follows release.
- Basic step and timing: load (0,0,0); `key_stb` → `rot_fast`=1, mid/slow=0; `enc_valid` pulses exactly 4 cycles after the update; `busy` is high for 5 cycles.
- Turnover and wrap: load (0,0,16); key → (0,1,17). Load (0,0,25); key → (0,0,0).
- Double step: load (0,3,16); key → (0,4,17); key → (1,5,18) with `ROTOR_DOUBLE_STEP_EN`, (0,4,18) without.
- Drops and abort: `key_stb` during SETTLE → positions unchanged, exactly one `enc_valid`. `load` (1,2,3) during SETTLE → `rot_*`=(1,2,3), `busy`=0 next cycle, no `enc_valid`.
- Load reduction: load (31,26,27) → (5,0,1).
